// File: rtl/seq_divider_4bit_pkg.sv
// Shared definitions for the sequential divider: FSM states, the quotient
// reported for a zero divisor, and the 7-segment encoder used by both displays.
package seq_divider_4bit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] DIV0_QUOTIENT = 4'hF;

    // Active-high segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] bin7seg(input logic [3:0] i_val);
        logic [6:0] v_seg;
        v_seg = '0;
        unique case (i_val)
            4'h0: v_seg = 7'h3F;
            4'h1: v_seg = 7'h06;
            4'h2: v_seg = 7'h5B;
            4'h3: v_seg = 7'h4F;
            4'h4: v_seg = 7'h66;
            4'h5: v_seg = 7'h6D;
            4'h6: v_seg = 7'h7D;
            4'h7: v_seg = 7'h07;
            4'h8: v_seg = 7'h7F;
            4'h9: v_seg = 7'h6F;
            4'hA: v_seg = 7'h77;
            4'hB: v_seg = 7'h7C;
            4'hC: v_seg = 7'h39;
            4'hD: v_seg = 7'h5E;
            4'hE: v_seg = 7'h79;
            4'hF: v_seg = 7'h71;
        endcase
        return v_seg;
    endfunction

endpackage

// File: rtl/seq_divider_4bit_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it does not borrow.
module div_step #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_q_msb,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic         o_q_bit
);

    logic [W:0] w_shift;
    logic [W:0] w_diff;

    always_comb begin
        w_shift = {i_rem, i_q_msb};
        w_diff  = w_shift - {1'b0, i_divisor};
        // Restored remainder is always below the divisor, so W bits suffice.
        if (!w_diff[W]) begin
            o_rem   = w_diff[W-1:0];
            o_q_bit = 1'b1;
        end else begin
            o_rem   = w_shift[W-1:0];
            o_q_bit = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider_4bit.sv
// Sequential unsigned restoring divider producing one quotient bit per clock,
// with 7-segment views of quotient/remainder and an LED echo of the operands.
module seq_divider_4bit
    import seq_divider_4bit_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [6:0]   seg_out1,
    output logic [6:0]   seg_out2,
    output logic [7:0]   led
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    state_t         r_state;
    state_t         w_next_state;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_div;
    logic [W-1:0]   r_rem;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   w_rem_next;
    logic           w_q_bit;
    logic           w_accept;
    logic           w_load;
    logic           w_div0;
    logic           w_last;

    div_step #(.W(W)) u_step (
        .i_rem     (r_rem),
        .i_q_msb   (r_q[W-1]),
        .i_divisor (r_div),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = IDLE;
        unique case (r_state)
            IDLE, DONE: begin
                if (start) w_next_state = (b == '0) ? DONE : RUN;
                else       w_next_state = IDLE;
            end
            RUN:     w_next_state = (r_cnt == CW'(W - 1)) ? DONE : RUN;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == RUN);
        done     = (r_state == DONE);
        w_accept = start && (r_state == IDLE || r_state == DONE);
        w_load   = w_accept && (b != '0);
        w_div0   = w_accept && (b == '0);
        w_last   = (r_state == RUN) && (r_cnt == CW'(W - 1));
    end

    // Results are written on the edge that enters DONE so they are valid with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            r_div       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_load) begin
            r_q         <= a;
            r_div       <= b;
            r_rem       <= '0;
            r_cnt       <= '0;
            div_by_zero <= 1'b0;
        end else if (w_div0) begin
            quotient    <= W'(DIV0_QUOTIENT);
            remainder   <= a;
            div_by_zero <= 1'b1;
        end else if (r_state == RUN) begin
            r_q   <= {r_q[W-2:0], w_q_bit};
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                quotient  <= {r_q[W-2:0], w_q_bit};
                remainder <= w_rem_next;
            end
        end
    end

    assign seg_out1 = bin7seg(quotient[3:0]);
    assign seg_out2 = bin7seg(remainder[3:0]);
    assign led      = {b[3:0], a[3:0]};

endmodule

// File: tb/tb_seq_divider_4bit.sv
// Self-checking bench for seq_divider_4bit against an arithmetic reference model.
module tb_seq_divider_4bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [3:0] quotient, remainder;
    logic       busy, done, div_by_zero;
    logic [6:0] seg_out1, seg_out2;
    logic [7:0] led;

    int checks = 0;
    int errors = 0;

    logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seq_divider_4bit #(.W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .seg_out1(seg_out1), .seg_out2(seg_out2), .led(led)
    );

    always #5 clk = ~clk;

    function automatic void model(input int ia, input int ib, output int q, output int r,
                                  output int z, output int lat);
        if (ib == 0) begin
            q = 15; r = ia; z = 1; lat = 1;
        end else begin
            q = ia / ib; r = ia % ib; z = 0; lat = 5;
        end
    endfunction

    // Pulses start for one edge and waits (bounded) for done; lat counts sample points.
    task automatic launch(input logic [3:0] ia, input logic [3:0] ib, output int lat,
                          output int busy_cyc);
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_cyc = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cyc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #3;
        checks++; if (quotient !== 4'd0) begin errors++; $display("FAIL reset_quot got %0d want 0", quotient); end
        checks++; if (remainder !== 4'd0) begin errors++; $display("FAIL reset_rem got %0d want 0", remainder); end
        checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero}); end
        checks++; if (seg_out1 !== SEG[0] || seg_out2 !== SEG[0]) begin errors++; $display("FAIL reset_seg got %h/%h want %h", seg_out1, seg_out2, SEG[0]); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [3:0] va [6];
        logic [3:0] vb [6];
        int lat, bc, q, r, z, el;
        va = '{4'd13, 4'd15, 4'd3, 4'd0, 4'd0, 4'd0};
        vb = '{4'd4, 4'd1, 4'd7, 4'd0, 4'd0, 4'd0};
        for (int i = 3; i < 6; i++) begin
            va[i] = 4'($urandom_range(0, 15));
            vb[i] = 4'($urandom_range(1, 15));
        end
        for (int i = 0; i < 6; i++) begin
            launch(va[i], vb[i], lat, bc);
            model(va[i], vb[i], q, r, z, el);
            checks++; if (lat != el) begin errors++; $display("FAIL basic_latency %0d/%0d got %0d want %0d", va[i], vb[i], lat, el); end
            checks++; if (bc != 4) begin errors++; $display("FAIL basic_busy %0d/%0d got %0d want 4", va[i], vb[i], bc); end
            checks++; if (quotient !== 4'(q) || remainder !== 4'(r)) begin errors++; $display("FAIL basic_result %0d/%0d got q=%0d r=%0d want q=%0d r=%0d", va[i], vb[i], quotient, remainder, q, r); end
            checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
            checks++; if (seg_out1 !== SEG[q] || seg_out2 !== SEG[r]) begin errors++; $display("FAIL basic_seg got %h/%h want %h/%h", seg_out1, seg_out2, SEG[q], SEG[r]); end
        end
    endtask

    task automatic test_div_zero;
        int lat, bc;
        launch(4'd9, 4'd0, lat, bc);
        checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
        checks++; if (quotient !== 4'hF || remainder !== 4'd9 || div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_result got q=%0d r=%0d z=%b want q=15 r=9 z=1", quotient, remainder, div_by_zero); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || div_by_zero !== 1'b1 || quotient !== 4'hF) begin errors++; $display("FAIL dz_hold got done=%b z=%b q=%0d want 0/1/15", done, div_by_zero, quotient); end
        launch(4'd8, 4'd2, lat, bc);
        checks++; if (quotient !== 4'd4 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_clear got q=%0d r=%0d z=%b want 4/0/0", quotient, remainder, div_by_zero); end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        a = 4'd10; b = 4'd3; start = 1'b1;
        @(negedge clk);
        a = 4'd15; b = 4'd15;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat != 5) begin errors++; $display("FAIL b2b_latency got %0d want 5", lat); end
        checks++; if (quotient !== 4'd3 || remainder !== 4'd1) begin errors++; $display("FAIL b2b_first got q=%0d r=%0d want 3/1", quotient, remainder); end
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_restart got busy=%b done=%b want 1/0", busy, done); end
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat != 5) begin errors++; $display("FAIL b2b_latency2 got %0d want 5", lat); end
        checks++; if (quotient !== 4'd1 || remainder !== 4'd0) begin errors++; $display("FAIL b2b_second got q=%0d r=%0d want 1/0", quotient, remainder); end
    endtask

    task automatic test_reset_mid_run;
        int lat, bc, seen_done;
        launch(4'd14, 4'd3, lat, bc);
        @(negedge clk);
        a = 4'd13; b = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (quotient !== 4'd0 || remainder !== 4'd0) begin errors++; $display("FAIL mid_reset_result got q=%0d r=%0d want 0/0", quotient, remainder); end
        checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL mid_reset_flags got %b want 000", {busy, done, div_by_zero}); end
        checks++; if (seg_out1 !== SEG[0] || seg_out2 !== SEG[0]) begin errors++; $display("FAIL mid_reset_seg got %h/%h want %h", seg_out1, seg_out2, SEG[0]); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL mid_reset_idle got %0d active cycles want 0", seen_done); end
        launch(4'd13, 4'd4, lat, bc);
        checks++; if (lat != 5 || quotient !== 4'd3 || remainder !== 4'd1) begin errors++; $display("FAIL mid_reset_recover got lat=%0d q=%0d r=%0d want 5/3/1", lat, quotient, remainder); end
    endtask

    task automatic test_sweep;
        int order [256];
        int j, t, ia, ib, q, r, z, el, lat, bc;
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            ia = order[i] % 16;
            ib = order[i] / 16;
            model(ia, ib, q, r, z, el);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            launch(4'(ia), 4'(ib), lat, bc);
            checks++; if (led !== {4'(ib), 4'(ia)}) begin errors++; $display("FAIL sweep_led got %h want %h", led, {4'(ib), 4'(ia)}); end
            checks++; if (lat != el) begin errors++; $display("FAIL sweep_latency %0d/%0d got %0d want %0d", ia, ib, lat, el); end
            checks++; if (quotient !== 4'(q) || remainder !== 4'(r) || div_by_zero !== 1'(z)) begin errors++; $display("FAIL sweep_result %0d/%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=%0d", ia, ib, quotient, remainder, div_by_zero, q, r, z); end
            checks++; if (seg_out1 !== SEG[q] || seg_out2 !== SEG[r]) begin errors++; $display("FAIL sweep_seg %0d/%0d got %h/%h want %h/%h", ia, ib, seg_out1, seg_out2, SEG[q], SEG[r]); end
            @(negedge clk);
            checks++; if (done !== 1'b0 || quotient !== 4'(q) || remainder !== 4'(r)) begin errors++; $display("FAIL sweep_pulse_hold %0d/%0d got done=%b q=%0d r=%0d want 0/%0d/%0d", ia, ib, done, quotient, remainder, q, r); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_div_zero;
        test_back_to_back;
        test_reset_mid_run;
        test_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
